// File: rtl/ltc2174_pkg.sv
// LTC2174 emulator shared definitions: register map, word geometry,
// register bit positions and the per-channel word builder.
package ltc2174_pkg;

    localparam logic [6:0] REG_RST   = 7'd0;
    localparam logic [6:0] REG_MODE  = 7'd1;
    localparam logic [6:0] REG_OUT   = 7'd2;
    localparam logic [6:0] REG_TP_HI = 7'd3;
    localparam logic [6:0] REG_TP_LO = 7'd4;

    localparam logic [7:0] FR_PAT_DEF = 8'hF0;
    localparam int SMP_W     = 14;
    localparam int WORD_W    = 16;
    localparam int LANE_BITS = 8;
    localparam int CNT_W     = $clog2(LANE_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANE_BITS - 1);

    localparam int R0_SWRST    = 7;
    localparam int R1_RAND     = 6;
    localparam int R1_TWOSCOMP = 5;
    localparam int R2_OUTOFF   = 3;
    localparam int R3_OUTTEST  = 7;

    typedef struct packed {
        logic             rnd;
        logic             twoscomp;
        logic [4:0]       sleep;
        logic             outoff;
        logic             outtest;
        logic [SMP_W-1:0] tp;
    } cfg_t;

    function automatic logic [WORD_W-1:0] build_word(
        input logic [SMP_W-1:0] s,
        input cfg_t             c
    );
        logic [SMP_W-1:0] d;
        d = c.outtest ? c.tp : s;
        if (c.twoscomp) d[SMP_W-1] = ~d[SMP_W-1];
        if (c.rnd) d[SMP_W-1:1] = d[SMP_W-1:1] ^ {(SMP_W-1){d[0]}};
        return {d, 2'b00};
    endfunction

endpackage

// File: rtl/ltc2174_spi_slave.sv
// SPI slave of the emulated ADC: input synchronizers, 16-bit frame
// shifter, register file 0-4 and read-data driver.
module ltc2174_spi_slave
    import ltc2174_pkg::*;
#(
    parameter int SYNC_STG = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        sck,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe,
    output logic [39:0] regs_o
);

    logic [SYNC_STG-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STG-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STG-1:0] sdi_sync_q, sdi_sync_d;
    logic                sck_prev_q, sck_prev_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [14:0]         sh_q, sh_d;
    logic [7:0]          rd_q, rd_d;
    logic                oe_q, oe_d;
    logic                sdo_q, sdo_d;
    logic [7:0]          r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
    logic [7:0]          r3_q, r3_d, r4_q, r4_d;

    logic       cs_s, sck_s, sdi_s, rise, fall;
    logic [6:0] hdr_addr, wr_addr;
    logic [7:0] wr_data, rd_mux;

    assign cs_s  = cs_sync_q[SYNC_STG-1];
    assign sck_s = sck_sync_q[SYNC_STG-1];
    assign sdi_s = sdi_sync_q[SYNC_STG-1];
    assign rise  = sck_s & ~sck_prev_q;
    assign fall  = ~sck_s & sck_prev_q;

    assign hdr_addr = {sh_q[5:0], sdi_s};
    assign wr_addr  = sh_q[13:7];
    assign wr_data  = {sh_q[6:0], sdi_s};

    always_comb begin
        cs_sync_d  = {cs_sync_q[SYNC_STG-2:0], cs};
        sck_sync_d = {sck_sync_q[SYNC_STG-2:0], sck};
        sdi_sync_d = {sdi_sync_q[SYNC_STG-2:0], sdi};
        sck_prev_d = sck_s;
        cnt_d = cnt_q;
        sh_d  = sh_q;
        rd_d  = rd_q;
        oe_d  = oe_q;
        sdo_d = sdo_q;
        r0_d  = r0_q;
        r1_d  = r1_q;
        r2_d  = r2_q;
        r3_d  = r3_q;
        r4_d  = r4_q;

        unique case (hdr_addr)
            REG_RST:   rd_mux = r0_q;
            REG_MODE:  rd_mux = r1_q;
            REG_OUT:   rd_mux = r2_q;
            REG_TP_HI: rd_mux = r3_q;
            REG_TP_LO: rd_mux = r4_q;
            default:   rd_mux = 8'h00;
        endcase

        if (cs_s) begin
            cnt_d = '0;
            sh_d  = '0;
            oe_d  = 1'b0;
            sdo_d = 1'b0;
        end else begin
            if (rise && cnt_q != 5'd16) begin
                sh_d  = {sh_q[13:0], sdi_s};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd7 && sh_q[6]) begin
                    oe_d = 1'b1;
                    rd_d = rd_mux;
                end
                if (cnt_q == 5'd15) begin
                    oe_d  = 1'b0;
                    sdo_d = 1'b0;
                    if (!sh_q[14]) begin
                        unique case (wr_addr)
                            REG_RST: begin
                                if (wr_data[R0_SWRST]) begin
                                    r0_d = '0;
                                    r1_d = '0;
                                    r2_d = '0;
                                    r3_d = '0;
                                    r4_d = '0;
                                end else begin
                                    r0_d = wr_data;
                                end
                            end
                            REG_MODE:  r1_d = wr_data;
                            REG_OUT:   r2_d = wr_data;
                            REG_TP_HI: r3_d = {wr_data[7], 1'b0, wr_data[5:0]};
                            REG_TP_LO: r4_d = wr_data;
                            default:   ;
                        endcase
                    end
                end
            end
            if (fall && oe_q) begin
                sdo_d = rd_q[7];
                rd_d  = {rd_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b0;
            cnt_q      <= '0;
            sh_q       <= '0;
            rd_q       <= '0;
            oe_q       <= 1'b0;
            sdo_q      <= 1'b0;
            r0_q       <= '0;
            r1_q       <= '0;
            r2_q       <= '0;
            r3_q       <= '0;
            r4_q       <= '0;
        end else begin
            cs_sync_q  <= cs_sync_d;
            sck_sync_q <= sck_sync_d;
            sdi_sync_q <= sdi_sync_d;
            sck_prev_q <= sck_prev_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            rd_q       <= rd_d;
            oe_q       <= oe_d;
            sdo_q      <= sdo_d;
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            r3_q       <= r3_d;
            r4_q       <= r4_d;
        end
    end

    assign sdo    = sdo_q;
    assign sdo_oe = oe_q;
    assign regs_o = {r1_q, r2_q, r3_q, r4_q, r0_q};

endmodule

// File: rtl/ltc2174_emu.sv
// LTC2174 emulator top: 2-lane SDR serializer with frame lane for four
// 14-bit channels, configured through the SPI register file.
module ltc2174_emu
    import ltc2174_pkg::*;
#(
    parameter int         NCH      = 4,
    parameter int         SYNC_STG = 2,
    parameter logic [7:0] FR_PAT   = FR_PAT_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [SMP_W*NCH-1:0] ch_data,
    output logic                 sample_stb,
    output logic [NCH-1:0]       adca_o,
    output logic [NCH-1:0]       adcb_o,
    output logic                 frame_o,
    input  logic                 cs,
    input  logic                 sck,
    input  logic                 sdi,
    output logic                 sdo,
    output logic                 sdo_oe,
    output logic [39:0]          cfg
);

    logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic [NCH-1:0][WORD_W-1:0]   word_q, word_d;
    logic                         lane_en_q, lane_en_d;
    logic                         fr_en_q, fr_en_d;
    logic [NCH-1:0]               adca_q, adca_d, adcb_q, adcb_d;
    logic                         frame_q, frame_d;
    logic                         stb_q, stb_d;

    logic             load;
    logic [CNT_W-1:0] bit_sel;
    logic [7:0]       reg1, reg2, reg3, reg4;
    cfg_t             c;

    ltc2174_spi_slave #(
        .SYNC_STG (SYNC_STG)
    ) u_spi (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .sck     (sck),
        .sdi     (sdi),
        .sdo     (sdo),
        .sdo_oe  (sdo_oe),
        .regs_o  (cfg)
    );

    assign reg1 = cfg[39:32];
    assign reg2 = cfg[31:24];
    assign reg3 = cfg[23:16];
    assign reg4 = cfg[15:8];

    always_comb begin
        c.rnd      = reg1[R1_RAND];
        c.twoscomp = reg1[R1_TWOSCOMP];
        c.sleep    = reg1[4:0];
        c.outoff   = reg2[R2_OUTOFF];
        c.outtest  = reg3[R3_OUTTEST];
        c.tp       = {reg3[5:0], reg4};
    end

    // Config is sampled only at the load edge so a word is never torn.
    always_comb begin
        load      = (bit_cnt_q == CNT_LAST);
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        word_d    = word_q;
        lane_en_d = lane_en_q;
        fr_en_d   = fr_en_q;
        if (load) begin
            for (int k = 0; k < NCH; k++) begin
                word_d[k] = build_word(ch_data[SMP_W*k +: SMP_W], c);
            end
            lane_en_d = !c.outoff && (c.sleep == 5'd0);
            fr_en_d   = !c.outoff;
        end
        bit_sel = CNT_LAST - bit_cnt_d;
        for (int k = 0; k < NCH; k++) begin
            adca_d[k] = lane_en_d & word_d[k][{bit_sel, 1'b1}];
            adcb_d[k] = lane_en_d & word_d[k][{bit_sel, 1'b0}];
        end
        frame_d = fr_en_d & FR_PAT[bit_sel];
        stb_d   = (bit_cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt_q <= '0;
            word_q    <= '0;
            lane_en_q <= 1'b0;
            fr_en_q   <= 1'b0;
            adca_q    <= '0;
            adcb_q    <= '0;
            frame_q   <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            lane_en_q <= lane_en_d;
            fr_en_q   <= fr_en_d;
            adca_q    <= adca_d;
            adcb_q    <= adcb_d;
            frame_q   <= frame_d;
            stb_q     <= stb_d;
        end
    end

    assign sample_stb = stb_q;
    assign adca_o     = adca_q;
    assign adcb_o     = adcb_q;
    assign frame_o    = frame_q;

endmodule

// File: tb/tb_ltc2174_emu.sv
// Directed bench for ltc2174_emu: serial word capture plus
// bit-banged SPI writes, reads and aborted frames.
module tb_ltc2174_emu;

    localparam int NCH = 4;
    localparam int HP  = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [55:0]   ch_data = '0;
    logic          sample_stb;
    logic [3:0]    adca_o, adcb_o;
    logic          frame_o;
    logic          cs = 1'b1;
    logic          sck = 1'b0;
    logic          sdi = 1'b0;
    logic          sdo, sdo_oe;
    logic [39:0]   cfg;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0][15:0] cap_w;
    logic [7:0]       cap_fr;
    logic [7:0]       rd_byte;
    logic             rd_oe;

    ltc2174_emu #(
        .NCH      (NCH),
        .SYNC_STG (2),
        .FR_PAT   (8'hF0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ch_data    (ch_data),
        .sample_stb (sample_stb),
        .adca_o     (adca_o),
        .adcb_o     (adcb_o),
        .frame_o    (frame_o),
        .cs         (cs),
        .sck        (sck),
        .sdi        (sdi),
        .sdo        (sdo),
        .sdo_oe     (sdo_oe),
        .cfg        (cfg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for the load strobe, then reassembles one word per channel.
    task automatic capture();
        int t = 0;
        while (sample_stb !== 1'b1 && t < 20) begin
            tick(1);
            t++;
        end
        if (sample_stb !== 1'b1) check("stb_wait", {63'd0, sample_stb}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            for (int k = 0; k < NCH; k++) begin
                cap_w[k][15-2*i] = adca_o[k];
                cap_w[k][14-2*i] = adcb_o[k];
            end
            cap_fr[7-i] = frame_o;
        end
    endtask

    task automatic spi_xfer(input logic [15:0] fr, input int nbits);
        rd_byte = '0;
        rd_oe   = 1'b0;
        cs = 1'b0;
        tick(HP);
        for (int i = 0; i < nbits; i++) begin
            sdi = fr[15-i];
            tick(HP);
            if (i >= 8) rd_byte[15-i] = sdo;
            if (i == 8) rd_oe = sdo_oe;
            sck = 1'b1;
            tick(HP);
            sck = 1'b0;
        end
        tick(HP);
        cs  = 1'b1;
        sdi = 1'b0;
        tick(HP);
    endtask

    task automatic spi_wr(input logic [6:0] a, input logic [7:0] d);
        spi_xfer({1'b0, a, d}, 16);
    endtask

    task automatic spi_rd(input logic [6:0] a);
        spi_xfer({1'b1, a, 8'h00}, 16);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        tick(3);
        check("rst_stb", {63'd0, sample_stb}, 64'd0);
        check("rst_adca", {60'd0, adca_o}, 64'd0);
        check("rst_adcb", {60'd0, adcb_o}, 64'd0);
        check("rst_frame", {63'd0, frame_o}, 64'd0);
        check("rst_sdo", {62'd0, sdo, sdo_oe}, 64'd0);
        check("rst_cfg", {24'd0, cfg}, 64'd0);
        reset_n = 1'b1;

        // Plain sample path
        ch_data = {14'h0, 14'h0, 14'h0, 14'h2AAA};
        capture();
        check("t1_ch0", {48'd0, cap_w[0]}, 64'h AAA8);
        check("t1_ch1", {48'd0, cap_w[1]}, 64'h0000);
        check("t1_frame", {56'd0, cap_fr}, 64'hF0);
        capture();
        check("t1_frame2", {56'd0, cap_fr}, 64'hF0);

        // Test pattern; bit6 of reg3 always stored as 0
        spi_wr(7'd3, 8'hC1);
        spi_wr(7'd4, 8'h55);
        check("t2_cfg", {24'd0, cfg}, 64'h00_00_81_55_00);
        capture();
        for (int k = 0; k < NCH; k++)
            check($sformatf("t2_ch%0d", k), {48'd0, cap_w[k]}, 64'h0554);
        spi_rd(7'd3);
        check("t2_rd3", {56'd0, rd_byte}, 64'h81);
        check("t2_rd3_oe", {63'd0, rd_oe}, 64'd1);
        spi_rd(7'd5);
        check("t2_rd5", {56'd0, rd_byte}, 64'h00);
        spi_wr(7'd5, 8'hFF);
        check("t2_wr5", {24'd0, cfg}, 64'h00_00_81_55_00);

        // Two's complement, then data randomizer
        spi_wr(7'd3, 8'h00);
        spi_wr(7'd1, 8'h20);
        ch_data = {14'h0, 14'h0, 14'h0000, 14'h2AAA};
        capture();
        check("t3_tc_ch1", {48'd0, cap_w[1]}, 64'h8000);
        check("t3_tc_ch0", {48'd0, cap_w[0]}, 64'h2AA8);
        spi_wr(7'd1, 8'h40);
        ch_data = {14'h0, 14'h0, 14'h0001, 14'h2AAA};
        capture();
        check("t3_rnd_ch1", {48'd0, cap_w[1]}, 64'hFFFC);
        check("t3_rnd_ch0", {48'd0, cap_w[0]}, 64'hAAA8);
        spi_wr(7'd1, 8'h00);

        // Aborted frame, then a full one
        spi_xfer({1'b0, 7'd2, 8'h47}, 10);
        check("t4_abort_reg2", {56'd0, cfg[31:24]}, 64'h00);
        check("t4_abort_oe", {63'd0, sdo_oe}, 64'd0);
        spi_wr(7'd2, 8'h47);
        check("t4_full_reg2", {56'd0, cfg[31:24]}, 64'h47);

        // outoff kills all lanes, sleep only the data lanes
        spi_wr(7'd2, 8'h08);
        capture();
        check("outoff_ch0", {48'd0, cap_w[0]}, 64'h0);
        check("outoff_frame", {56'd0, cap_fr}, 64'h00);
        spi_wr(7'd2, 8'h00);
        spi_wr(7'd1, 8'h01);
        capture();
        check("sleep_ch0", {48'd0, cap_w[0]}, 64'h0);
        check("sleep_frame", {56'd0, cap_fr}, 64'hF0);
        spi_wr(7'd1, 8'h00);

        // Software reset
        spi_wr(7'd1, 8'h80);
        spi_wr(7'd2, 8'h47);
        spi_wr(7'd3, 8'h12);
        spi_wr(7'd4, 8'h34);
        check("t5_prog", {24'd0, cfg}, 64'h80_47_12_34_00);
        spi_wr(7'd0, 8'h80);
        check("t5_cfg", {24'd0, cfg}, 64'd0);
        for (int a = 1; a <= 4; a++) begin
            spi_rd(7'(a));
            check($sformatf("t5_rd%0d", a), {56'd0, rd_byte}, 64'h00);
        end
        capture();
        check("t5_ch0", {48'd0, cap_w[0]}, 64'hAAA8);
        check("t5_frame", {56'd0, cap_fr}, 64'hF0);

        // Reset at bit_cnt==5
        capture();
        tick(5);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("t6_stb", {63'd0, sample_stb}, 64'd0);
        check("t6_adca", {60'd0, adca_o}, 64'd0);
        check("t6_adcb", {60'd0, adcb_o}, 64'd0);
        check("t6_frame", {63'd0, frame_o}, 64'd0);
        n = 1;
        while (sample_stb !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check("t6_stb_cycle", 64'(n), 64'd8);
        capture();
        check("t6_ch0", {48'd0, cap_w[0]}, 64'hAAA8);
        check("t6_frame2", {56'd0, cap_fr}, 64'hF0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
